// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: bus width, controller command encoding
// and the port identifiers used for grant/owner tracking.
package mem_arbiter_pkg;

    localparam int BUS_WIDTH = 8;

    typedef enum logic [2:0] {
        NONE  = 3'b000,
        READ  = 3'b001,
        WRITE = 3'b010
    } mc_cmd_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } port_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between fetch and data ports; on contention the
// port that did not win last time is chosen.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic  req_if,
    input  logic  req_dm,
    input  port_t last_grant,
    output logic  valid,
    output port_t grant
);

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        valid = req_if | req_dm;
        grant = PORT_IF;
        if (req_if && req_dm) begin
            grant = (last_grant == PORT_IF) ? PORT_DM : PORT_IF;
        end else if (req_dm) begin
            grant = PORT_DM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory_controller between instruction fetch and load/store:
// round-robin grant, one command per access, one-cycle done pulse to the winner.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [BUS_WIDTH-1:0] if_addr,
    output logic                 if_done,
    output logic [BUS_WIDTH-1:0] if_rdata,
    input  logic                 dm_req,
    input  logic                 dm_we,
    input  logic [BUS_WIDTH-1:0] dm_addr,
    input  logic [BUS_WIDTH-1:0] dm_wdata,
    output logic                 dm_done,
    output logic [BUS_WIDTH-1:0] dm_rdata,
    output logic [2:0]           mc_write_read,
    output logic [BUS_WIDTH-1:0] mc_addr,
    output logic [BUS_WIDTH-1:0] mc_write_data,
    input  logic [BUS_WIDTH-1:0] mc_read_data,
    input  logic                 mc_busy,
    output logic                 owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    arb_state_t           state_q, state_d;
    port_t                grant_q;
    port_t                pick;
    logic                 pick_valid;
    logic                 start;
    logic                 we_q;
    logic [BUS_WIDTH-1:0] addr_q;
    logic [BUS_WIDTH-1:0] wdata_q;
    logic [BUS_WIDTH-1:0] rdata_q;
    logic [BUS_WIDTH-1:0] rdata_out;

    rr_arbiter2 u_rr (
        .req_if     (if_req),
        .req_dm     (dm_req),
        .last_grant (grant_q),
        .valid      (pick_valid),
        .grant      (pick)
    );

    assign start = (state_q == IDLE) && !mc_busy && pick_valid;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: holding registers are reset too, so no stale data can reach an output.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= PORT_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (start) begin
                grant_q <= pick;
                if (pick == PORT_DM) begin
                    we_q    <= dm_we;
                    addr_q  <= dm_addr;
                    wdata_q <= dm_wdata;
                end else begin
                    we_q    <= 1'b0;
                    addr_q  <= if_addr;
                    wdata_q <= '0;
                end
            end
            if (state_q == WAIT) begin
                rdata_q <= mc_read_data;
            end
        end
    end

    // Stores return zero so the data port never sees unrelated controller data.
    assign rdata_out = we_q ? '0 : rdata_q;

    always_comb begin
        state_d       = state_q;
        mc_write_read = NONE;
        mc_addr       = '0;
        mc_write_data = '0;
        if_done       = 1'b0;
        dm_done       = 1'b0;
        if_rdata      = '0;
        dm_rdata      = '0;
        case (state_q)
            IDLE: begin
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                mc_write_read = we_q ? WRITE : READ;
                mc_addr       = addr_q;
                mc_write_data = wdata_q;
                state_d       = WAIT;
            end
            WAIT: begin
                mc_addr = addr_q;
                state_d = DONE;
            end
            DONE: begin
                if (grant_q == PORT_DM) begin
                    dm_done  = 1'b1;
                    dm_rdata = rdata_out;
                end else begin
                    if_done  = 1'b1;
                    if_rdata = rdata_out;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign owner = grant_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single `memory_controller` between the instruction-fetch unit (read-only) and the load/store unit (read/write). It accepts level-held requests from both ports, picks one by round-robin, drives one command to the controller, captures the read data and returns a one-cycle `done` pulse to the winner. It sits between the CPU core and `memory_controller`, and is the only block allowed to drive the controller's command inputs.

## Interface
- `BUS_WIDTH`: taken from `params.svh`, no local override. Width of address and data.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `if_req`  in  1  fetch request, held until `if_done`.
- `if_addr`  in  BUS_WIDTH  fetch address, stable while `if_req` is high.
- `if_done`  out  1  one-cycle pulse, fetch complete.
- `if_rdata`  out  BUS_WIDTH  fetched word, valid while `if_done` is high.
- `dm_req`  in  1  data request, held until `dm_done`.
- `dm_we`  in  1  1 = store, 0 = load; stable while `dm_req` is high.
- `dm_addr`  in  BUS_WIDTH  data address.
- `dm_wdata`  in  BUS_WIDTH  store data.
- `dm_done`  out  1  one-cycle pulse, data access complete.
- `dm_rdata`  out  BUS_WIDTH  load result, valid while `dm_done` is high; 0 for stores.
- `mc_write_read`  out  3  controller command: 3'b010 write, 3'b001 read, 3'b000 none.
- `mc_addr`  out  BUS_WIDTH  controller address.
- `mc_write_data`  out  BUS_WIDTH  controller write data.
- `mc_read_data`  in  BUS_WIDTH  controller `read_data`.
- `mc_busy`  in  1  controller `busy`.
- `owner`  out  1  current/last grant: 0 = fetch, 1 = data (debug).

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if `mc_busy` = 0 and any request is pending, latch the winner into `grant`, latch its addr/we/wdata into holding registers, and go to ISSUE. Otherwise stay in IDLE.
- Arbitration: when only one request is pending, that requester wins. When both are pending, the winner is the port not named by `last_grant`. `last_grant` updates when the state is left IDLE.
- ISSUE: drive `mc_write_read` (010 if store, else 001), `mc_addr` and `mc_write_data` from the holding registers for exactly one cycle. Go to WAIT.
- WAIT: hold `mc_addr`, drive `mc_write_read` = 000, and register `mc_read_data` into `rdata_q`. Go to DONE.
- DONE: pulse `done` for the granted port only. Present `rdata_q` on that port's rdata, or 0 if it was a store. Go to IDLE.
- `mc_write_read` = 000 in every state except ISSUE; bit 2 is never driven to 1.
- A requester that keeps `req` high after its `done` is treated as a new request. It is arbitrated normally in the next IDLE.
- Changing a request's inputs, or dropping `req`, after the grant has no effect; the latched values are used.

## Timing
- Reset values: state IDLE, `last_grant` = fetch, every output 0 (`mc_write_read` = 000, both `done` = 0, both rdata = 0, `owner` = 0).
- Reset mid-operation: return to IDLE next edge and emit no `done`. A write already issued may still complete in RAM; this is accepted.
- Latency: request seen in IDLE at cycle N, command at N+1, data captured at N+2, `done` at N+3.
- Throughput: one access per 4 cycles. Two back-to-back requesters alternate.
- `mc_busy` high in IDLE blocks issue. It is ignored in the other states.
- `rdata` ports are 0 whenever their `done` is 0.

## Structure
- `params.svh` holds `BUS_WIDTH` and a new shared `mc_cmd_t` enum: NONE = 3'b000, READ = 3'b001, WRITE = 3'b010. `memory_controller` and this block both use it.
- The `arb_state_t` typedef is local to the module.
- One sub-module is natural: `rr_arbiter2`, a 2-way round-robin pick that takes `last_grant` as input. The FSM stays in `mem_arbiter`.

## Test plan
- Fetch only: `if_req`, `if_addr` = 8'h10, RAM[10] = 8'hA5 → `mc_write_read` = 001 with `mc_addr` = 10 at N+1; `if_done` = 1 with `if_rdata` = A5 at N+3; `dm_done` stays 0.
- Store: `dm_req`, `dm_we` = 1, `dm_addr` = 8'h20, `dm_wdata` = 8'h3C → 010/20/3C at N+1; `dm_done` at N+3 with `dm_rdata` = 0; a later load of 20 returns 3C.
- Simultaneous requests after reset: both held → data granted first (done N+3), then fetch (done N+7); with both still held, grants keep alternating.
- Reset at N+2 during a fetch: no `if_done`; all outputs 0 the next cycle; a new request then completes normally with 3-cycle latency.
- `mc_busy` forced high for 5 cycles in IDLE with `if_req` high → no command issued until `mc_busy` falls; `done` arrives 3 cycles after that.
- Request inputs changed after the grant (`if_addr` 10→30 at N+1) → `mc_addr` remains 10 through WAIT.
